// File: rtl/tulong_mem_pkg.sv
// Shared encodings for the memory-side arbiters: FSM states, op codes and
// performance counter width.
package tulong_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    localparam int unsigned PERF_CNT_BITS = 32;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: grants the first requester found scanning
// upward from the port after i_last_grant, wrapping at NUM_PORTS.
module rr_priority_picker #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PTR_BITS  = 3
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_BITS-1:0]  i_last_grant,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [PTR_BITS-1:0]  o_grant_idx,
    output logic                 o_any_req
);

    int unsigned w_pos;
    logic        w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_pos       = 0;
        // k runs 1..NUM_PORTS so the last granted port is examined last
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            w_pos = (32'(i_last_grant) + k) % NUM_PORTS;
            if (!w_found && i_req[w_pos]) begin
                w_found          = 1'b1;
                o_grant[w_pos]   = 1'b1;
                o_grant_idx      = PTR_BITS'(w_pos);
            end
        end
        o_any_req = |i_req;
    end

endmodule

// File: rtl/rr_memory_arbiter.sv
// Round-robin arbiter of NUM_PORTS requesters onto one memory port, one
// transaction outstanding. Optional perf counters under RR_ARB_PERF_CNT_EN.
module rr_memory_arbiter
    import tulong_mem_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned PTR_BITS     = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req_read,
    input  logic [NUM_PORTS-1:0]              req_write,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0] req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_PORTS-1:0]              req_accept,
    output logic [NUM_PORTS-1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]             resp_data,
    output logic [ADDRESS_BITS-1:0]           resp_address,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDRESS_BITS-1:0]           mem_address_out,
    output logic [DATA_WIDTH-1:0]             mem_data_out,
    input  logic                              mem_ready,
    input  logic                              mem_valid,
    input  logic [DATA_WIDTH-1:0]             mem_data_in,
    input  logic [ADDRESS_BITS-1:0]           mem_address_in,
    output logic                              busy
`ifdef RR_ARB_PERF_CNT_EN
    ,
    output logic [NUM_PORTS*PERF_CNT_BITS-1:0] grant_count,
    output logic [PERF_CNT_BITS-1:0]           stall_cycles
`endif
);

    arb_state_t               r_state, w_next_state;
    logic [PTR_BITS-1:0]      r_last_grant;
    logic [NUM_PORTS-1:0]     w_req, w_grant;
    logic [PTR_BITS-1:0]      w_grant_idx;
    logic                     w_any_req, w_take;
    logic [ADDRESS_BITS-1:0]  r_addr, w_sel_addr;
    logic [DATA_WIDTH-1:0]    r_data, w_sel_data;
    mem_op_t                  r_op, w_sel_op;
    logic [NUM_PORTS-1:0]     r_resp_valid;
    logic [DATA_WIDTH-1:0]    r_resp_data;
    logic [ADDRESS_BITS-1:0]  r_resp_addr;

    assign w_req = req_read | req_write;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_BITS  (PTR_BITS)
    ) u_picker (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any_req    (w_any_req)
    );

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_req && mem_ready) begin
                    w_take       = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (mem_valid) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Read+write together on one port resolves to a write
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_op   = OP_READ;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_grant[p]) begin
                w_sel_addr = req_address[p*ADDRESS_BITS +: ADDRESS_BITS];
                w_sel_data = req_data[p*DATA_WIDTH +: DATA_WIDTH];
                w_sel_op   = req_write[p] ? OP_WRITE : OP_READ;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= PTR_BITS'(NUM_PORTS - 1);
            r_addr       <= '0;
            r_data       <= '0;
            r_op         <= OP_READ;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_addr  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= '0;
            if (w_take) begin
                r_addr       <= w_sel_addr;
                r_data       <= w_sel_data;
                r_op         <= w_sel_op;
                r_last_grant <= w_grant_idx;
            end
            if (r_state == WAIT && mem_valid) begin
                r_resp_valid <= NUM_PORTS'(1) << r_last_grant;
                r_resp_data  <= mem_data_in;
                r_resp_addr  <= mem_address_in;
            end
        end
    end

    assign req_accept      = (w_take && !reset) ? w_grant : '0;
    assign resp_valid      = r_resp_valid;
    assign resp_data       = r_resp_data;
    assign resp_address    = r_resp_addr;
    assign mem_read        = (r_state == ISSUE) && (r_op == OP_READ);
    assign mem_write       = (r_state == ISSUE) && (r_op == OP_WRITE);
    assign mem_address_out = r_addr;
    assign mem_data_out    = r_data;
    assign busy            = (r_state != IDLE);

`ifdef RR_ARB_PERF_CNT_EN
    logic [PERF_CNT_BITS-1:0] r_grant_cnt [NUM_PORTS];
    logic [PERF_CNT_BITS-1:0] r_stall_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                r_grant_cnt[p] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (req_accept[p] && r_grant_cnt[p] != '1) begin
                    r_grant_cnt[p] <= r_grant_cnt[p] + PERF_CNT_BITS'(1);
                end
            end
            if (r_state == IDLE && w_any_req && !mem_ready && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + PERF_CNT_BITS'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
        assign grant_count[g*PERF_CNT_BITS +: PERF_CNT_BITS] = r_grant_cnt[g];
    end
    assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rr_memory_arbiter.sv
// Directed-vector bench for rr_memory_arbiter (4 ports, 32-bit data/address).
// Inputs change 1ns after the rising edge; outputs are sampled 4ns after it.
module tb_rr_memory_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [NP-1:0]    req_read, req_write, req_accept, resp_valid;
    logic [NP*AW-1:0] req_address;
    logic [NP*DW-1:0] req_data;
    logic [DW-1:0]    resp_data, mem_data_out, mem_data_in;
    logic [AW-1:0]    resp_address, mem_address_out, mem_address_in;
    logic             mem_read, mem_write, mem_ready, mem_valid, busy;
`ifdef RR_ARB_PERF_CNT_EN
    logic [NP*32-1:0] grant_count;
    logic [31:0]      stall_cycles;
`endif

    rr_memory_arbiter #(
        .NUM_PORTS    (NP),
        .DATA_WIDTH   (DW),
        .ADDRESS_BITS (AW),
        .PTR_BITS     (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_data        (req_data),
        .req_accept      (req_accept),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_address    (resp_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address_out (mem_address_out),
        .mem_data_out    (mem_data_out),
        .mem_ready       (mem_ready),
        .mem_valid       (mem_valid),
        .mem_data_in     (mem_data_in),
        .mem_address_in  (mem_address_in),
        .busy            (busy)
`ifdef RR_ARB_PERF_CNT_EN
        ,
        .grant_count     (grant_count),
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        req_read       = '0;
        req_write      = '0;
        req_address    = '0;
        req_data       = '0;
        mem_ready      = 1'b1;
        mem_valid      = 1'b0;
        mem_data_in    = '0;
        mem_address_in = '0;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        req_address[p*AW +: AW] = a;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) step();
        settle();
        check_eq("rst_accept",   64'(req_accept), 64'h0);
        check_eq("rst_resp_v",   64'(resp_valid), 64'h0);
        check_eq("rst_rd",       64'(mem_read), 64'h0);
        check_eq("rst_wr",       64'(mem_write), 64'h0);
        check_eq("rst_addr",     64'(mem_address_out), 64'h0);
        check_eq("rst_busy",     64'(busy), 64'h0);
        check_eq("rst_rdata",    64'(resp_data), 64'h0);
        reset = 1'b0;

        // Reset while WAITing drops the transaction
        step(); req_read[1] = 1'b1; set_addr(1, 32'h100); settle();
        check_eq("mw_accept",    64'(req_accept), 64'b0010);
        step(); req_read = '0; settle();
        check_eq("mw_rd",        64'(mem_read), 64'h1);
        check_eq("mw_addr",      64'(mem_address_out), 64'h100);
        step(); settle();
        check_eq("mw_busy",      64'(busy), 64'h1);
        #1; reset = 1'b1; mem_valid = 1'b1; mem_data_in = 32'hBAD; #1;
        check_eq("mw_rst_busy",  64'(busy), 64'h0);
        check_eq("mw_rst_addr",  64'(mem_address_out), 64'h0);
        check_eq("mw_rst_resp",  64'(resp_valid), 64'h0);
        step(); step();
        reset = 1'b0; mem_valid = 1'b0;
        req_read = 4'b0011; set_addr(0, 32'h10); settle();
        check_eq("mw_regrant",   64'(req_accept), 64'b0001);
        check_eq("mw_no_resp",   64'(resp_valid), 64'h0);
        step(); req_read = '0; settle();
        check_eq("mw_no_resp2",  64'(resp_valid), 64'h0);
        check_eq("mw_addr2",     64'(mem_address_out), 64'h10);

        // Single read on port 2
        do_reset();
        step(); req_read[2] = 1'b1; set_addr(2, 32'h40); settle();
        check_eq("sr_accept",    64'(req_accept), 64'b0100);
        check_eq("sr_rd0",       64'(mem_read), 64'h0);
        step(); req_read = '0; settle();
        check_eq("sr_rd1",       64'(mem_read), 64'h1);
        check_eq("sr_addr",      64'(mem_address_out), 64'h40);
        step(); mem_valid = 1'b1; mem_data_in = 32'hDEADBEEF; mem_address_in = 32'h40; settle();
        check_eq("sr_rd2",       64'(mem_read), 64'h0);
        check_eq("sr_resp_v2",   64'(resp_valid), 64'h0);
        step(); mem_valid = 1'b0; settle();
        check_eq("sr_resp_v",    64'(resp_valid), 64'b0100);
        check_eq("sr_resp_d",    64'(resp_data), 64'hDEADBEEF);
        check_eq("sr_resp_a",    64'(resp_address), 64'h40);
        check_eq("sr_idle",      64'(busy), 64'h0);
        step(); settle();
        check_eq("sr_resp_off",  64'(resp_valid), 64'h0);
        check_eq("sr_hold_d",    64'(resp_data), 64'hDEADBEEF);

        // All four ports requesting continuously: order 0,1,2,3,0
        do_reset();
        step();
        req_read = 4'b1111;
        for (int p = 0; p < NP; p++) set_addr(p, 32'h1000 + 32'(p) * 4);
        for (int g = 0; g < 5; g++) begin
            int ep;
            int pp;
            ep = g % NP;
            pp = (g + NP - 1) % NP;
            mem_valid = 1'b0;
            settle();
            check_eq($sformatf("rr_accept%0d", g), 64'(req_accept), 64'(1 << ep));
            if (g > 0) begin
                check_eq($sformatf("rr_resp%0d", g), 64'(resp_valid), 64'(1 << pp));
                check_eq($sformatf("rr_rdat%0d", g), 64'(resp_data), 64'(32'hA0 + 32'(pp)));
            end
            step(); settle();
            check_eq($sformatf("rr_rd%0d", g), 64'(mem_read), 64'h1);
            check_eq($sformatf("rr_addr%0d", g), 64'(mem_address_out), 64'(32'h1000 + 32'(ep) * 4));
            check_eq($sformatf("rr_gap1_%0d", g), 64'(req_accept), 64'h0);
            step();
            mem_valid = 1'b1; mem_data_in = 32'hA0 + 32'(ep); mem_address_in = 32'h1000 + 32'(ep) * 4;
            settle();
            check_eq($sformatf("rr_gap2_%0d", g), 64'(req_accept), 64'h0);
            step();
        end
        mem_valid = 1'b0;

        // mem_ready low for 5 cycles while port 3 requests
        do_reset();
        step();
        mem_ready = 1'b0; req_read[3] = 1'b1; set_addr(3, 32'h300);
        for (int c = 0; c < 5; c++) begin
            settle();
            check_eq($sformatf("st_noacc%0d", c), 64'(req_accept), 64'h0);
            check_eq($sformatf("st_nord%0d", c), 64'(mem_read), 64'h0);
            step();
        end
        mem_ready = 1'b1; settle();
        check_eq("st_accept",    64'(req_accept), 64'b1000);
        step(); req_read = '0; settle();
        check_eq("st_rd",        64'(mem_read), 64'h1);
        check_eq("st_addr",      64'(mem_address_out), 64'h300);
`ifdef RR_ARB_PERF_CNT_EN
        check_eq("st_stall",     64'(stall_cycles), 64'd5);
        check_eq("st_gcnt3",     64'(grant_count[3*32 +: 32]), 64'd1);
        check_eq("st_gcnt0",     64'(grant_count[0 +: 32]), 64'd0);
`endif

        // Port 0 read and write together resolves to a write
        do_reset();
        step();
        req_read[0] = 1'b1; req_write[0] = 1'b1; set_addr(0, 32'h8); req_data[0 +: 32] = 32'h55;
        settle();
        check_eq("rw_accept",    64'(req_accept), 64'b0001);
        step(); req_read = '0; req_write = '0; settle();
        check_eq("rw_wr",        64'(mem_write), 64'h1);
        check_eq("rw_rd",        64'(mem_read), 64'h0);
        check_eq("rw_data",      64'(mem_data_out), 64'h55);
        check_eq("rw_addr",      64'(mem_address_out), 64'h8);
        step(); mem_valid = 1'b1; mem_address_in = 32'h8; settle();
        check_eq("rw_wr_off",    64'(mem_write), 64'h0);
        step(); mem_valid = 1'b0; settle();
        check_eq("rw_resp",      64'(resp_valid), 64'b0001);

        // Slow memory: ports 1 and 3 held; mem_valid in ISSUE is ignored
        do_reset();
        step();
        req_read = 4'b1010; set_addr(1, 32'h11); set_addr(3, 32'h33);
        settle();
        check_eq("sl_accept1",   64'(req_accept), 64'b0010);
        step(); mem_valid = 1'b1; mem_data_in = 32'hBAD; settle();
        check_eq("sl_rd",        64'(mem_read), 64'h1);
        step(); mem_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            settle();
            check_eq($sformatf("sl_busy%0d", c), 64'(busy), 64'h1);
            check_eq($sformatf("sl_noacc%0d", c), 64'(req_accept), 64'h0);
            check_eq($sformatf("sl_noresp%0d", c), 64'(resp_valid), 64'h0);
            step();
        end
        mem_valid = 1'b1; mem_data_in = 32'h1111; mem_address_in = 32'h11; settle();
        check_eq("sl_noacc_v",   64'(req_accept), 64'h0);
        step(); mem_valid = 1'b0; settle();
        check_eq("sl_resp",      64'(resp_valid), 64'b0010);
        check_eq("sl_rdata",     64'(resp_data), 64'h1111);
        check_eq("sl_accept3",   64'(req_accept), 64'b1000);
        step(); req_read = '0; settle();
        check_eq("sl_addr3",     64'(mem_address_out), 64'h33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rr_memory_arbiter.md
Name: rr_memory_arbiter

Overview:
- Parametrised successor to the fixed two-port fetch/memory interface.
- Arbitrates NUM_PORTS requesters onto one downstream memory port using round-robin and one outstanding transaction.
- Routes each response back to the requester that issued it.
- Sits between one or more pipeline cores (fetch and memory stages) and a shared single-cycle or multi-cycle memory subsystem.

Parameters:
- NUM_PORTS, 4, number of requesters; legal range 2..8.
- DATA_WIDTH, 32, data bus width.
- ADDRESS_BITS, 32, address width.
- PTR_BITS, 3, width of the grant index; must satisfy 2**PTR_BITS >= NUM_PORTS.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_read  in  NUM_PORTS  per-port read request (level).
- req_write  in  NUM_PORTS  per-port write request (level).
- req_address  in  NUM_PORTS*ADDRESS_BITS  per-port address; port p occupies slice [p*ADDRESS_BITS +: ADDRESS_BITS].
- req_data  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- req_accept  out  NUM_PORTS  one-hot, one-cycle pulse: the port's request was captured this cycle.
- resp_valid  out  NUM_PORTS  one-hot, one-cycle pulse: response for that port.
- resp_data  out  DATA_WIDTH  shared response data; valid only with resp_valid.
- resp_address  out  ADDRESS_BITS  shared response address.
- mem_read  out  1  downstream read strobe.
- mem_write  out  1  downstream write strobe.
- mem_address_out  out  ADDRESS_BITS  downstream address.
- mem_data_out  out  DATA_WIDTH  downstream write data.
- mem_ready  in  1  downstream can accept a request.
- mem_valid  in  1  downstream response or write acknowledge.
- mem_data_in  in  DATA_WIDTH  downstream read data.
- mem_address_in  in  ADDRESS_BITS  downstream response address.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs are 0.
  - last_grant = NUM_PORTS-1, so port 0 wins first.
  - The captured request registers are cleared.
  - A transaction in flight is dropped; no resp_valid is produced for it.
- State machine: IDLE, ISSUE, WAIT.
- IDLE:
  - A port is requesting when req_read|req_write is high.
  - If any port is requesting and mem_ready=1, grant the first requesting port scanning (last_grant+1) mod NUM_PORTS upward.
  - In the same cycle, req_accept[grant] is high (combinational).
  - At the edge, capture the port's address, data and op into registers, set last_grant=grant, and go to ISSUE.
  - If mem_ready=0, no accept is issued and the FSM stays in IDLE.
- ISSUE (exactly one cycle):
  - mem_read or mem_write = 1 from the registers; address and data are driven from the registers.
  - Next state is WAIT.
- WAIT:
  - Strobes are 0; address and data hold their values.
  - On mem_valid=1, register mem_data_in and mem_address_in, then go to IDLE.
  - In the following cycle, resp_valid[last_grant]=1 for one cycle.
- Latency: request in cycle 0 → accept in cycle 0 → strobe in cycle 1 → earliest mem_valid in cycle 2 → resp_valid in cycle 3.
  - A new grant may occur in the same cycle as resp_valid, giving a throughput of one transaction per 3 cycles minimum.
- Requester rules:
  - After req_accept, the requester may drop its request or present a new one.
  - A request held past its accept is treated as a new request and arbitrated again.
- Simultaneous req_read and req_write on one port: treated as a write.
- mem_valid in IDLE or ISSUE: ignored (protocol error).
- resp_data and resp_address hold their last values between pulses.
- Round-robin fairness: a continuously requesting port waits at most NUM_PORTS-1 grants.
- A requester that drops its request before accept loses nothing; no state is kept for it.

Optional Feature:
- Macro: RR_ARB_PERF_CNT_EN.
- When defined, add output grant_count (NUM_PORTS*32):
  - Per-port count of accepted requests, saturating at 32'hFFFFFFFF.
  - Counters are cleared by reset.
- When defined, also add output stall_cycles (32):
  - Counts cycles in IDLE with some request pending and mem_ready=0.
  - Saturating; cleared by reset.
- When not defined, these ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package tulong_mem_pkg holds:
  - State encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - Op encodings OP_READ=1'b0, OP_WRITE=1'b1.
  - Counter width constant PERF_CNT_BITS=32.
- Sub-module rr_priority_picker:
  - Combinational.
  - Inputs: request vector and last_grant.
  - Outputs: one-hot grant, grant index and any_req.
  - Reusable by future cache arbiters.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: port 1 read at address 0x100 accepted; assert reset in WAIT; release.
  - Required: all outputs 0, no resp_valid, and the next grant goes to port 0 if it is requesting.
- Single read:
  - Stimulus: port 2 read at address 0x40 with the memory returning 0xDEADBEEF one cycle after the strobe.
  - Required: req_accept=4'b0100 in cycle 0, mem_read in cycle 1, resp_valid=4'b0100 with resp_data=0xDEADBEEF in cycle 3.
- All four ports requesting continuously:
  - Required: grant order 0,1,2,3,0.
  - Required: each resp_valid routed to its matching port.
  - Required: accepts spaced 3 cycles apart.
- mem_ready held low for 5 cycles while port 3 requests:
  - Required: no accept and no strobe during those cycles; accept on the first cycle mem_ready=1.
  - Required (with RR_ARB_PERF_CNT_EN): stall_cycles=5.
- Port 0 asserts read and write together at address 0x8 with data 0x55:
  - Required: mem_write=1 with mem_data_out=0x55; resp_valid[0] on the acknowledge.
- Memory delays mem_valid by 10 cycles while ports 1 and 3 request:
  - Required: busy stays high, port 3 gets no accept until port 1's response, then port 3 is granted.
